ai_move_m: RTL and testbench
============================

Name: ai_move_m

Overview:
Computer-opponent move generator sitting directly upstream of board_m. It watches `turn`. When the turn passes to the AI, it snapshots the board and scans for a move by fixed priority: win, block, centre, corner, edge. It then drives `update_loc` and a `submit` pulse, whose falling edge commits the move in board_m. One clock domain; sequential scan of one line per cycle.

Parameters:
SUBMIT_CYCLES, 2, number of clocks `submit` is held high (min 1).
ENABLE_BLOCK, 1, 1 = run block pass; 0 = skip it (easy difficulty).

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high; clears FSM and outputs.
turn  input  `FLAG_T  current turn from board_m.
board  input  `BOARD_T `STATE_T  live cell contents from board_m.
update_loc  output  `INDEX_T  chosen cell index (row*`BOARD_ROWS+col).
submit  output  `FLAG_T  move strobe to board_m; board_m commits on its falling edge.
busy  output  1  high from trigger until return to IDLE.
no_move  output  1  one-cycle pulse when AI's turn arrives on a full board.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; update_loc=`INDEX_INVALID (15); submit=0; busy=0; no_move=0; turn_q=`TURN_PLAYER; line=0; hold counter=0. Reset wins over every other event, including mid-scan and mid-submit. submit is low the cycle after reset is sampled.
- Trigger: rising edge E0 where turn==`TURN_AI and turn_q==`TURN_PLAYER. At E0: latch board into snap, line=0, busy=1, state=SCAN_WIN. turn_q<=turn every cycle.
- Abort: in any state other than IDLE/WAIT_TURN, if turn==`TURN_PLAYER is sampled, go to IDLE, busy=0, submit=0. update_loc keeps its value. This covers board_m reset.
- AI mark = `CELL_O; opponent mark = `CELL_X.
- Line table, index 0..7: (0,1,2) (3,4,5) (6,7,8) (0,3,6) (1,4,7) (2,5,8) (0,4,8) (2,4,6).
- SCAN_WIN:
  - Each edge evaluates snap on table[line].
  - Hit = exactly two AI marks plus one `CELL_BLANK`. On hit: update_loc=blank index, submit=1, state=SUBMIT.
  - Otherwise line++. After line 7 with no hit: line=0, state=SCAN_BLOCK (or SELECT if ENABLE_BLOCK=0).
  - A win on line k asserts submit after edge E(k+1).
- SCAN_BLOCK: same as SCAN_WIN using the opponent mark. A block on line k asserts submit after E(9+k).
- SELECT (1 cycle): first blank in order 4,0,2,6,8,1,3,5,7. Found: update_loc=index, submit=1, state=SUBMIT. Empty-board move is submitted after E17. None found: no_move=1 for one cycle, state=IDLE, busy=0.
- SUBMIT: hold submit high for SUBMIT_CYCLES clocks total, counted from the edge it rose. Then submit=0, state=WAIT_TURN. update_loc stays stable through and after the falling edge.
- WAIT_TURN: stay until turn==`TURN_PLAYER, then IDLE, busy=0. If board_m rejects the move and turn stays AI, the block stays in WAIT_TURN; no retry.
- First matching line in table order wins; a line with three blanks or mixed marks never hits.
- Width: per-line counts are 2 bits; line counter 3 bits; hold counter $clog2(SUBMIT_CYCLES+1) bits.

Decomposition:
- Shared defines.v additions:
  - `INDEX_INVALID (15).
  - `NUM_LINES (8) and the line table as `LINE_CELL(l,i) macro.
  - `CELL_AI/`CELL_OPP aliases to `CELL_O/`CELL_X.
  - FSM state codes `AI_IDLE, `AI_SCAN_WIN, `AI_SCAN_BLOCK, `AI_SELECT, `AI_SUBMIT, `AI_WAIT_TURN.
- One combinational sub-module, line_eval_m: inputs three cells and a mark; outputs hit and the blank's position (0..2). It is instantiated once and fed by the line mux.

Test Plan:
- Empty board, turn 0→1 at E0 -> update_loc=4, submit rises after E17, high 2 cycles, no_move stays 0, busy drops after turn returns 0.
- O at 0,1; X at 3,4; trigger -> update_loc=2 after E1 (win beats block on line 1).
- X at 0,4; O at 2; trigger -> update_loc=8 (block, diag line 6) after E15; ENABLE_BLOCK=0 same board -> update_loc=6 after E9.
- Full board (no blanks), trigger -> no_move pulses one cycle after E9 of SELECT path (E17), submit never rises, update_loc unchanged.
- Trigger, then turn forced to 0 at E5 -> state IDLE at E5, submit never asserted; re-trigger later scans fresh snapshot.
- reset asserted during SUBMIT (submit high) -> submit=0, update_loc=15, busy=0 next cycle; no further activity until a new 0→1 turn edge.

Source files
------------

// File: rtl/ai_move_m_pkg.sv
// Shared types, encodings and line/preference tables for the tic-tac-toe AI move generator.
package ai_move_m_pkg;

    typedef logic        flag_t;
    typedef logic [1:0]  cell_t;
    typedef cell_t [8:0] board_t;
    typedef logic [3:0]  index_t;

    localparam cell_t CELL_BLANK = 2'd0;
    localparam cell_t CELL_X     = 2'd1;
    localparam cell_t CELL_O     = 2'd2;
    localparam cell_t CELL_AI    = CELL_O;
    localparam cell_t CELL_OPP   = CELL_X;

    localparam flag_t TURN_PLAYER = 1'b0;
    localparam flag_t TURN_AI     = 1'b1;

    localparam index_t INDEX_INVALID = 4'd15;
    localparam int     NUM_LINES     = 8;

    localparam logic [2:0] AI_IDLE       = 3'd0;
    localparam logic [2:0] AI_SCAN_WIN   = 3'd1;
    localparam logic [2:0] AI_SCAN_BLOCK = 3'd2;
    localparam logic [2:0] AI_SELECT     = 3'd3;
    localparam logic [2:0] AI_SUBMIT     = 3'd4;
    localparam logic [2:0] AI_WAIT_TURN  = 3'd5;

    // Cell index of position i (0..2) on line l: rows, columns, then diagonals.
    function automatic index_t line_cell(input logic [2:0] l, input logic [1:0] i);
        index_t c0, c1, c2;
        case (l)
            3'd0:    begin c0 = 4'd0; c1 = 4'd1; c2 = 4'd2; end
            3'd1:    begin c0 = 4'd3; c1 = 4'd4; c2 = 4'd5; end
            3'd2:    begin c0 = 4'd6; c1 = 4'd7; c2 = 4'd8; end
            3'd3:    begin c0 = 4'd0; c1 = 4'd3; c2 = 4'd6; end
            3'd4:    begin c0 = 4'd1; c1 = 4'd4; c2 = 4'd7; end
            3'd5:    begin c0 = 4'd2; c1 = 4'd5; c2 = 4'd8; end
            3'd6:    begin c0 = 4'd0; c1 = 4'd4; c2 = 4'd8; end
            default: begin c0 = 4'd2; c1 = 4'd4; c2 = 4'd6; end
        endcase
        case (i)
            2'd0:    return c0;
            2'd1:    return c1;
            default: return c2;
        endcase
    endfunction

    // Fallback preference: centre, corners, then edges.
    function automatic index_t select_cell(input logic [3:0] k);
        case (k)
            4'd0:    return 4'd4;
            4'd1:    return 4'd0;
            4'd2:    return 4'd2;
            4'd3:    return 4'd6;
            4'd4:    return 4'd8;
            4'd5:    return 4'd1;
            4'd6:    return 4'd3;
            4'd7:    return 4'd5;
            default: return 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/ai_move_m_line_eval.sv
// Evaluates one board line: hits when it holds exactly two of `mark` and one blank.
module line_eval_m
    import ai_move_m_pkg::*;
(
    input  cell_t      a,
    input  cell_t      b,
    input  cell_t      c,
    input  cell_t      mark,
    output logic       hit,
    output logic [1:0] pos
);

    logic [1:0] mark_count;
    logic [1:0] blank_count;

    always_comb begin
        mark_count  = {1'b0, a == mark} + {1'b0, b == mark} + {1'b0, c == mark};
        blank_count = {1'b0, a == CELL_BLANK} + {1'b0, b == CELL_BLANK} + {1'b0, c == CELL_BLANK};
        hit         = (mark_count == 2'd2) && (blank_count == 2'd1);
        pos         = 2'd0;
        if (c == CELL_BLANK) pos = 2'd2;
        if (b == CELL_BLANK) pos = 2'd1;
        if (a == CELL_BLANK) pos = 2'd0;
    end

endmodule

// File: rtl/ai_move_m.sv
// Computer opponent: on the player->AI turn edge, scans a board snapshot for win, block,
// then preference order, and strobes the chosen cell to board_m via submit.
module ai_move_m
    import ai_move_m_pkg::*;
#(
    parameter int SUBMIT_CYCLES = 2,
    parameter int ENABLE_BLOCK  = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  flag_t  turn,
    input  board_t board,
    output index_t update_loc,
    output flag_t  submit,
    output logic   busy,
    output logic   no_move
);

    localparam int              HOLD_W    = $clog2(SUBMIT_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SUBMIT_CYCLES);
    localparam logic [2:0]      LAST_LINE = 3'(NUM_LINES - 1);

    logic [2:0]        state;
    logic [2:0]        line;
    logic [HOLD_W-1:0] hold;
    flag_t             turn_q;
    board_t            snap;

    cell_t             scan_mark;
    logic              line_hit;
    logic [1:0]        line_pos;
    logic              sel_found;
    index_t            sel_idx;
    logic              abort;

    assign scan_mark = (state == AI_SCAN_BLOCK) ? CELL_OPP : CELL_AI;
    assign abort     = (turn == TURN_PLAYER);

    line_eval_m u_line_eval (
        .a    (snap[line_cell(line, 2'd0)]),
        .b    (snap[line_cell(line, 2'd1)]),
        .c    (snap[line_cell(line, 2'd2)]),
        .mark (scan_mark),
        .hit  (line_hit),
        .pos  (line_pos)
    );

    // Walk the preference list backwards so the earliest blank entry ends up selected.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = INDEX_INVALID;
        for (int k = 8; k >= 0; k--) begin
            if (snap[select_cell(4'(k))] == CELL_BLANK) begin
                sel_found = 1'b1;
                sel_idx   = select_cell(4'(k));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= AI_IDLE;
            update_loc <= INDEX_INVALID;
            submit     <= 1'b0;
            busy       <= 1'b0;
            no_move    <= 1'b0;
            turn_q     <= TURN_PLAYER;
            line       <= 3'd0;
            hold       <= '0;
            snap       <= '0;
        end else begin
            turn_q  <= turn;
            no_move <= 1'b0;
            case (state)
                AI_IDLE: begin
                    if (turn == TURN_AI && turn_q == TURN_PLAYER) begin
                        snap  <= board;
                        line  <= 3'd0;
                        busy  <= 1'b1;
                        state <= AI_SCAN_WIN;
                    end
                end
                AI_SCAN_WIN, AI_SCAN_BLOCK: begin
                    if (abort) begin
                        state <= AI_IDLE;
                        busy  <= 1'b0;
                        submit <= 1'b0;
                    end else if (line_hit) begin
                        update_loc <= line_cell(line, line_pos);
                        submit     <= 1'b1;
                        hold       <= HOLD_W'(1);
                        state      <= AI_SUBMIT;
                    end else if (line == LAST_LINE) begin
                        line  <= 3'd0;
                        state <= (state == AI_SCAN_WIN && ENABLE_BLOCK != 0) ? AI_SCAN_BLOCK : AI_SELECT;
                    end else begin
                        line <= line + 3'd1;
                    end
                end
                AI_SELECT: begin
                    if (abort) begin
                        state  <= AI_IDLE;
                        busy   <= 1'b0;
                        submit <= 1'b0;
                    end else if (sel_found) begin
                        update_loc <= sel_idx;
                        submit     <= 1'b1;
                        hold       <= HOLD_W'(1);
                        state      <= AI_SUBMIT;
                    end else begin
                        no_move <= 1'b1;
                        busy    <= 1'b0;
                        state   <= AI_IDLE;
                    end
                end
                // hold counts clocks since submit rose; board_m commits on the falling edge.
                AI_SUBMIT: begin
                    if (abort) begin
                        state  <= AI_IDLE;
                        busy   <= 1'b0;
                        submit <= 1'b0;
                        hold   <= '0;
                    end else if (hold == HOLD_LAST) begin
                        submit <= 1'b0;
                        hold   <= '0;
                        state  <= AI_WAIT_TURN;
                    end else begin
                        hold <= hold + HOLD_W'(1);
                    end
                end
                AI_WAIT_TURN: begin
                    if (turn == TURN_PLAYER) begin
                        state <= AI_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= AI_IDLE;
                    busy   <= 1'b0;
                    submit <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ai_move_m.sv
// Bench for ai_move_m: two instances (default, and SUBMIT_CYCLES=1 / no block pass) checked
// against a rule-level move model over directed and random boards.
module tb_ai_move_m;
    import ai_move_m_pkg::board_t;
    import ai_move_m_pkg::index_t;

    localparam int B = 0;
    localparam int X = 1;
    localparam int O = 2;

    logic   clk = 1'b0;
    logic   reset;
    logic   turn;
    board_t board;

    index_t loc_w     [2];
    logic   submit_w  [2];
    logic   busy_w    [2];
    logic   no_move_w [2];

    int tests_run    = 0;
    int tests_failed = 0;
    int prev_loc [2];
    int cells    [9];

    int line_tab [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                            '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int pref     [9]    = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

    always #5 clk = ~clk;

    ai_move_m #(.SUBMIT_CYCLES(2), .ENABLE_BLOCK(1)) dut0 (
        .clk(clk), .reset(reset), .turn(turn), .board(board),
        .update_loc(loc_w[0]), .submit(submit_w[0]), .busy(busy_w[0]), .no_move(no_move_w[0])
    );

    ai_move_m #(.SUBMIT_CYCLES(1), .ENABLE_BLOCK(0)) dut1 (
        .clk(clk), .reset(reset), .turn(turn), .board(board),
        .update_loc(loc_w[1]), .submit(submit_w[1]), .busy(busy_w[1]), .no_move(no_move_w[1])
    );

    function automatic int sc_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic t);
        for (int i = 0; i < 9; i++) board[i] = 2'(cells[i]);
        turn = t;
    endtask

    task automatic setBoard(input string s);
        for (int i = 0; i < 9; i++)
            cells[i] = (s[i] == "X") ? X : (s[i] == "O") ? O : B;
    endtask

    // Rule-level reference: win pass, optional block pass, then preference order.
    task automatic modelMove(input int d, output int lat, output int idx, output bit nomove);
        bit eb = (d == 0);
        bit found = 0;
        idx = 15;
        lat = 0;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1 && !eb) continue;
            for (int l = 0; l < 8; l++) begin
                int nm = 0;
                int nb = 0;
                int bp = 0;
                for (int j = 0; j < 3; j++) begin
                    if (cells[line_tab[l][j]] == ((pass == 0) ? O : X)) nm++;
                    else if (cells[line_tab[l][j]] == B) begin nb++; bp = line_tab[l][j]; end
                end
                if (!found && nm == 2 && nb == 1) begin
                    found = 1;
                    idx   = bp;
                    lat   = (pass == 0) ? l + 1 : 9 + l;
                end
            end
        end
        nomove = 0;
        if (!found) begin
            lat    = eb ? 17 : 9;
            nomove = 1;
            for (int k = 0; k < 9; k++)
                if (nomove && cells[pref[k]] == B) begin idx = pref[k]; nomove = 0; end
        end
    endtask

    task automatic runMove(input string name);
        int lat [2];
        int idx [2];
        bit nm  [2];
        applyStimulus(1'b0);
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s/d%0d/idle_busy", name, d), 32'(busy_w[d]), 32'd0);
            modelMove(d, lat[d], idx[d], nm[d]);
        end
        applyStimulus(1'b1);
        tick();
        for (int d = 0; d < 2; d++)
            checkOutput($sformatf("%s/d%0d/busy@E0", name, d), 32'(busy_w[d]), 32'd1);
        for (int c = 1; c <= 22; c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                bit exp_sub  = !nm[d] && c >= lat[d] && c < lat[d] + sc_of(d);
                bit exp_busy = nm[d] ? (c < lat[d]) : 1'b1;
                checkOutput($sformatf("%s/d%0d/submit@E%0d", name, d, c), 32'(submit_w[d]), 32'(exp_sub));
                checkOutput($sformatf("%s/d%0d/busy@E%0d", name, d, c), 32'(busy_w[d]), 32'(exp_busy));
                checkOutput($sformatf("%s/d%0d/no_move@E%0d", name, d, c), 32'(no_move_w[d]),
                            32'(nm[d] && c == lat[d]));
                if (!nm[d] && c == lat[d])
                    checkOutput($sformatf("%s/d%0d/loc@E%0d", name, d, c), 32'(loc_w[d]), 32'(idx[d]));
            end
        end
        for (int d = 0; d < 2; d++) begin
            int exp_loc = nm[d] ? prev_loc[d] : idx[d];
            checkOutput($sformatf("%s/d%0d/loc_final", name, d), 32'(loc_w[d]), 32'(exp_loc));
            prev_loc[d] = exp_loc;
        end
    endtask

    initial begin
        reset = 1'b1;
        setBoard(".........");
        applyStimulus(1'b0);
        prev_loc[0] = 15;
        prev_loc[1] = 15;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset/d%0d/loc", d), 32'(loc_w[d]), 32'd15);
            checkOutput($sformatf("reset/d%0d/submit", d), 32'(submit_w[d]), 32'd0);
            checkOutput($sformatf("reset/d%0d/busy", d), 32'(busy_w[d]), 32'd0);
            checkOutput($sformatf("reset/d%0d/no_move", d), 32'(no_move_w[d]), 32'd0);
        end
        reset = 1'b0;

        setBoard(".........");  runMove("empty");
        setBoard("OO.XX....");  runMove("win_over_block");
        setBoard("X.O.X....");  runMove("block_diag");
        setBoard("XOXXOOOXX");  runMove("full");

        // Abort: turn returns to the player, sampled at E5.
        setBoard(".........");
        applyStimulus(1'b0);
        tick();
        tick();
        applyStimulus(1'b1);
        tick();
        for (int c = 1; c <= 4; c++) tick();
        applyStimulus(1'b0);
        tick();
        for (int d = 0; d < 2; d++)
            checkOutput($sformatf("abort/d%0d/busy@E5", d), 32'(busy_w[d]), 32'd0);
        for (int c = 6; c <= 25; c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("abort/d%0d/submit@E%0d", d, c), 32'(submit_w[d]), 32'd0);
                checkOutput($sformatf("abort/d%0d/busy@E%0d", d, c), 32'(busy_w[d]), 32'd0);
            end
        end
        for (int d = 0; d < 2; d++)
            checkOutput($sformatf("abort/d%0d/loc", d), 32'(loc_w[d]), 32'(prev_loc[d]));
        setBoard("X...O..X.");  runMove("retrigger");

        // Reset while dut0 holds submit high.
        setBoard(".........");
        applyStimulus(1'b0);
        tick();
        tick();
        applyStimulus(1'b1);
        tick();
        for (int c = 1; c <= 18; c++) tick();
        checkOutput("midreset/d0/submit_before", 32'(submit_w[0]), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0);
        tick();
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("midreset/d%0d/submit", d), 32'(submit_w[d]), 32'd0);
            checkOutput($sformatf("midreset/d%0d/loc", d), 32'(loc_w[d]), 32'd15);
            checkOutput($sformatf("midreset/d%0d/busy", d), 32'(busy_w[d]), 32'd0);
            prev_loc[d] = 15;
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("postreset/d%0d/busy%0d", d, c), 32'(busy_w[d]), 32'd0);
                checkOutput($sformatf("postreset/d%0d/submit%0d", d, c), 32'(submit_w[d]), 32'd0);
            end
        end

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 9; i++) cells[i] = int'($urandom_range(0, 2));
            runMove($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
